// File: rtl/cipo_phase_pkg.sv
// Shared constants and types for CIPO phase selection.
// One SCLK period spans OVERSAMPLE samples; the DDR word trails the
// regular word by DDR_OFFSET samples (half an SCLK period).
package cipo_phase_pkg;

    localparam int SAMPLES    = 74;
    localparam int WORD_BITS  = 16;
    localparam int OVERSAMPLE = 4;
    localparam int DDR_OFFSET = 2;
    localparam int MAX_PHASE  = 11;
    localparam int PHASE_W    = 4;

    typedef logic [SAMPLES-1:0]   oversample_t;
    typedef logic [PHASE_W-1:0]   phase_t;
    typedef logic [WORD_BITS-1:0] word_t;

endpackage

// File: rtl/cipo_word_extractor.sv
// Picks one 16-bit word out of the oversampled CIPO vector.
// Output bit k (MSB first on the wire) comes from sample
// OVERSAMPLE*(WORD_BITS-1-k) + phase + OFFSET. Phases above MAX_PHASE
// force the word to zero so a misconfigured cable delay shows up as
// an all-zero word instead of reaching past the end of the vector.
module cipo_word_extractor
    import cipo_phase_pkg::*;
#(
    parameter int OFFSET = 0
) (
    input  phase_t      phase,
    input  oversample_t cipo4x,
    output word_t       word
);

    for (genvar k = 0; k < WORD_BITS; k++) begin : g_bit
        // One tap per possible phase code; illegal codes tie to zero,
        // leaving a 12:1 selection per bit plus zero forcing.
        logic [(1 << PHASE_W)-1:0] taps;

        for (genvar p = 0; p < (1 << PHASE_W); p++) begin : g_tap
            if (p <= MAX_PHASE) begin : g_legal
                assign taps[p] = cipo4x[OVERSAMPLE*(WORD_BITS-1-k) + p + OFFSET];
            end else begin : g_zero
                assign taps[p] = 1'b0;
            end
        end

        // Purely combinational selection: no latency through the data path.
        assign word[k] = taps[phase];
    end

endmodule

// File: rtl/cipo_combined_phase_selector.sv
// Recovers the regular word A and the DDR word B from one 4x-oversampled
// CIPO line. Only the phase setting is registered; the data path is
// combinational so the core can capture CIPO the cycle after the final
// oversample lands in CIPO4x.
module cipo_combined_phase_selector
    import cipo_phase_pkg::*;
(
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [PHASE_W-1:0]    phase_select,
    input  logic [SAMPLES-1:0]    CIPO4x,
    output logic [2*WORD_BITS-1:0] CIPO
);

    phase_t phase_q;
    word_t  word_a;
    word_t  word_b;

    // Phase register: new setting takes effect one cycle later; reset forces phase 0.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_select;
        end
    end

    // Regular word, aligned to SCLK rising edges.
    cipo_word_extractor #(
        .OFFSET (0)
    ) u_word_a (
        .phase  (phase_q),
        .cipo4x (CIPO4x),
        .word   (word_a)
    );

    // DDR word, half an SCLK period after the regular word.
    cipo_word_extractor #(
        .OFFSET (DDR_OFFSET)
    ) u_word_b (
        .phase  (phase_q),
        .cipo4x (CIPO4x),
        .word   (word_b)
    );

    assign CIPO = {word_b, word_a};

endmodule

// File: tb/tb_cipo_combined_phase_selector.sv
// Bench for cipo_combined_phase_selector: directed cases from the test plan
// followed by randomized phase/data/reset traffic against a reference model.
module tb_cipo_combined_phase_selector;

    logic        clk;
    logic        rstn;
    logic [3:0]  phase_select;
    logic [73:0] cipo4x;
    logic [31:0] cipo;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];

    // Model of the phase the DUT should currently be using.
    int  exp_phase  = 0;

    cipo_combined_phase_selector dut (
        .clk          (clk),
        .rstn         (rstn),
        .phase_select (phase_select),
        .CIPO4x       (cipo4x),
        .CIPO         (cipo)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    // Word A bit k = sample 4*(15-k)+p, word B bit k = sample 4*(15-k)+p+2;
    // phases beyond 11 yield zero.
    function automatic logic [31:0] ref_cipo(input logic [73:0] v, input int p);
        logic [31:0] r;
        r = '0;
        if (p >= 0 && p <= 11) begin
            for (int k = 0; k < 16; k++) begin
                r[k]      = v[4*(15-k) + p];
                r[16 + k] = v[4*(15-k) + p + 2];
            end
        end
        return r;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // Scoreboard: compare the DUT output against the oldest queued expectation.
    task automatic check_sb(input string tag);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, cipo, 32'hDEAD_BEEF);
        end else begin
            e = exp_q.pop_front();
            check(tag, cipo, e);
        end
    endtask

    // ---------------- driver ----------------
    // Drive new inputs at the falling edge. The data path must respond
    // immediately using the phase already registered; after the rising edge
    // the newly sampled phase (or 0 under reset) is in force.
    task automatic step(input logic [3:0] ph, input logic [73:0] data, input logic rst_n,
                        input bit check_comb);
        @(negedge clk);
        phase_select = ph;
        cipo4x       = data;
        rstn         = rst_n;
        #1;
        if (check_comb) begin
            exp_q.push_back(ref_cipo(cipo4x, exp_phase));
            check_sb("comb");
        end
        @(posedge clk);
        exp_phase = rst_n ? int'(ph) : 0;
        #1;
        exp_q.push_back(ref_cipo(cipo4x, exp_phase));
        check_sb("seq");
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [73:0] v;
        logic [3:0]  ph;
        logic        r;

        rstn         = 1'b0;
        phase_select = 4'd0;
        cipo4x       = '0;

        // Reset for two cycles (phase register unknown before the first edge).
        step(4'd0, 74'h0, 1'b0, 1'b0);
        step(4'd0, 74'h0, 1'b0, 1'b1);

        // Index 0
        step(4'd0, 74'h1, 1'b1, 1'b1);
        check("index0", cipo, 32'h0000_8000);

        // DDR lane
        step(4'd0, 74'h1 << 2, 1'b1, 1'b1);
        check("ddr_lane", cipo, 32'h8000_0000);

        // Upper bound
        step(4'd11, 74'h1 << 73, 1'b1, 1'b1);
        check("upper_p11", cipo, 32'h0001_0000);
        step(4'd13, 74'h1 << 73, 1'b1, 1'b1);
        check("upper_p13", cipo, 32'h0000_0000);

        // Phase sweep with all ones
        for (int p = 0; p < 16; p++) begin
            step(4'(p), {74{1'b1}}, 1'b1, 1'b1);
            check($sformatf("sweep_p%0d", p), cipo, (p <= 11) ? 32'hFFFF_FFFF : 32'h0);
        end

        // Alternating pattern at phase 3
        v = '0;
        for (int k = 0; k < 16; k += 2) v[4*(15-k) + 3] = 1'b1;
        step(4'd3, v, 1'b1, 1'b1);
        check("pattern_lo", {16'h0, cipo[15:0]}, 32'h0000_5555);

        // Latency: phase 0 -> 1 with sample 1 set
        step(4'd0, 74'h1 << 1, 1'b1, 1'b1);
        check("lat_p0", cipo, 32'h0);
        @(negedge clk);
        phase_select = 4'd1;
        #1;
        check("lat_hold", cipo, 32'h0);
        @(posedge clk);
        exp_phase = 1;
        #1;
        check("lat_p1", cipo, 32'h0000_8000);

        // Reset mid-operation reverts to phase 0
        step(4'd1, 74'h1 << 1, 1'b0, 1'b1);
        check("reset_mid", cipo, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            v  = {$urandom(), $urandom(), $urandom()};
            ph = (($urandom_range(0, 7)) == 0) ? 4'($urandom_range(12, 15))
                                               : 4'($urandom_range(0, 11));
            r  = ($urandom_range(0, 15) != 0);
            step(ph, v, r, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Safety bound on run length.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
